// File: rtl/seq_scan_pkg.sv
// Shared types for the sequence-scan controller and its embedded detector.
//   ctrl_state_t : controller FSM states (IDLE/SHIFT/DRAIN/REPORT)
//   det_state_t  : 3-bit Moore detector states for "101" and "0100"
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } ctrl_state_t;

  typedef enum logic [2:0] {
    START = 3'd0,
    S1    = 3'd1,
    S0    = 3'd2,
    S10   = 3'd3,
    S01   = 3'd4,
    S101  = 3'd5,
    S010  = 3'd6,
    S0100 = 3'd7
  } det_state_t;

endpackage

// File: rtl/seq_det.sv
// Moore detector for overlapping "101" and "0100" on a serial bit stream.
// Ports:
//   ck      clock (state updates on falling edge)
//   rs      asynchronous active-low reset
//   clr     synchronous return to START
//   en      advance the detector with bit_in
//   bit_in  serial input bit
//   y1      registered: state is S101
//   y2      registered: state is S0100
module seq_det
  import seq_scan_pkg::*;
(
  input  logic ck,
  input  logic rs,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic y1,
  output logic y2
);

  det_state_t state;
  det_state_t nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      START: nxt = bit_in ? S1   : S0;
      S1:    nxt = bit_in ? S1   : S10;
      S0:    nxt = bit_in ? S01  : S0;
      S10:   nxt = bit_in ? S101 : S0;
      S01:   nxt = bit_in ? S1   : S010;
      S101:  nxt = bit_in ? S1   : S010;
      S010:  nxt = bit_in ? S101 : S0100;
      S0100: nxt = bit_in ? S01  : S0;
    endcase
  end

  // Outputs are registered from the next state so they always match state.
  always_ff @(negedge ck or negedge rs) begin
    if (!rs) begin
      state <= START;
      y1    <= 1'b0;
      y2    <= 1'b0;
    end else if (clr) begin
      state <= START;
      y1    <= 1'b0;
      y2    <= 1'b0;
    end else if (en) begin
      state <= nxt;
      y1    <= (nxt == S101);
      y2    <= (nxt == S0100);
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Sequences W-bit words MSB-first through seq_det and reports per-word hit
// counts over a valid/ready handshake. Detector state persists across words.
// Optional feature: define SEQ_SCAN_TOTALS_EN for saturating cumulative
// totals (parameter CW, ports total1/total2).
// Ports:
//   ck, rs               falling-edge clock, async active-low reset
//   in_valid/in_ready    word handshake, in_data scanned MSB first
//   clr                  in IDLE: reset detector (and totals); blocks accept
//   out_valid/out_ready  result handshake
//   out_hit1/out_hit2    "101"/"0100" completions in the last word
//   total1/total2        saturating totals (SEQ_SCAN_TOTALS_EN only)
//   busy                 high in SHIFT, DRAIN and REPORT
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int W = 8
`ifdef SEQ_SCAN_TOTALS_EN
  , parameter int CW = 8
`endif
) (
  input  logic                     ck,
  input  logic                     rs,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(W+1)-1:0]   out_hit1,
  output logic [$clog2(W+1)-1:0]   out_hit2,
`ifdef SEQ_SCAN_TOTALS_EN
  output logic [CW-1:0]            total1,
  output logic [CW-1:0]            total2,
`endif
  output logic                     busy
);

  localparam int HW = $clog2(W + 1);
  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  ctrl_state_t   state;
  logic [W-1:0]  shreg;
  logic [IW-1:0] idx;
  logic          det_en;
  logic          det_bit;
  logic          det_clr;
  logic          y1;
  logic          y2;
  logic          sample;

  assign det_en   = (state == SHIFT);
  assign det_bit  = shreg[idx];
  assign det_clr  = clr && (state == IDLE);
  assign in_ready = (state == IDLE) && !clr;
  assign out_valid = (state == REPORT);
  assign busy     = (state != IDLE);

  // y1/y2 lag the shifted bit by one edge: the first SHIFT edge still shows
  // the previous word's last bit (already counted by its DRAIN edge).
  assign sample = ((state == SHIFT) && (idx != LAST_IDX)) || (state == DRAIN);

  seq_det u_det (
    .ck     (ck),
    .rs     (rs),
    .clr    (det_clr),
    .en     (det_en),
    .bit_in (det_bit),
    .y1     (y1),
    .y2     (y2)
  );

  always_ff @(negedge ck or negedge rs) begin
    if (!rs) begin
      state    <= IDLE;
      shreg    <= '0;
      idx      <= '0;
      out_hit1 <= '0;
      out_hit2 <= '0;
    end else begin
      if (sample) begin
        if (y1) out_hit1 <= out_hit1 + HW'(1);
        if (y2) out_hit2 <= out_hit2 + HW'(1);
      end
      unique case (state)
        IDLE: begin
          if (!clr && in_valid) begin
            shreg    <= in_data;
            idx      <= LAST_IDX;
            out_hit1 <= '0;
            out_hit2 <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx == '0) state <= DRAIN;
          else           idx   <= idx - 1'b1;
        end
        DRAIN:  state <= REPORT;
        REPORT: if (out_ready) state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_SCAN_TOTALS_EN
  always_ff @(negedge ck or negedge rs) begin
    if (!rs) begin
      total1 <= '0;
      total2 <= '0;
    end else if (det_clr) begin
      total1 <= '0;
      total2 <= '0;
    end else if (sample) begin
      if (y1 && (total1 != '1)) total1 <= total1 + CW'(1);
      if (y2 && (total2 != '1)) total2 <= total2 + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl. Stimulus pushes expected results from a
// bit-history reference model; a monitor compares on each result handshake.
module tb_seq_scan_ctrl;

  localparam int W  = 8;
  localparam int HW = $clog2(W + 1);
`ifdef SEQ_SCAN_TOTALS_EN
  localparam int CW   = 3;
  localparam int TMAX = (1 << CW) - 1;
`endif

  logic          ck = 1'b1;
  logic          rs = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          clr = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [HW-1:0] out_hit1;
  logic [HW-1:0] out_hit2;
`ifdef SEQ_SCAN_TOTALS_EN
  logic [CW-1:0] total1;
  logic [CW-1:0] total2;
`endif

  seq_scan_ctrl #(
    .W(W)
`ifdef SEQ_SCAN_TOTALS_EN
    , .CW(CW)
`endif
  ) dut (
    .ck        (ck),
    .rs        (rs),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hit1  (out_hit1),
    .out_hit2  (out_hit2),
`ifdef SEQ_SCAN_TOTALS_EN
    .total1    (total1),
    .total2    (total2),
`endif
    .busy      (busy)
  );

  always #5 ck = ~ck;

  typedef struct {
    int h1;
    int h2;
    int t1;
    int t2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  bit   rnd_rdy = 1'b0;

  // Reference model: the last four bits seen since reset/clr and their count.
  logic [3:0] hist;
  int         nbits;
  int         mt1;
  int         mt2;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist  = '0;
    nbits = 0;
    mt1   = 0;
    mt2   = 0;
  endtask

  task automatic model_word(input logic [W-1:0] w, output exp_t e);
    int h1 = 0;
    int h2 = 0;
    for (int i = W - 1; i >= 0; i--) begin
      hist = {hist[2:0], w[i]};
      nbits++;
      if (nbits >= 3 && hist[2:0] == 3'b101) h1++;
      if (nbits >= 4 && hist == 4'b0100) h2++;
    end
    mt1 += h1;
    mt2 += h2;
`ifdef SEQ_SCAN_TOTALS_EN
    if (mt1 > TMAX) mt1 = TMAX;
    if (mt2 > TMAX) mt2 = TMAX;
`endif
    e.h1 = h1;
    e.h2 = h2;
    e.t1 = mt1;
    e.t2 = mt2;
  endtask

  // Monitor: a result is consumed on the edge following valid && ready.
  always @(posedge ck) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out_hit1", int'(out_hit1), mon_e.h1);
        check("out_hit2", int'(out_hit2), mon_e.h2);
`ifdef SEQ_SCAN_TOTALS_EN
        check("total1", int'(total1), mon_e.t1);
        check("total2", int'(total2), mon_e.t2);
`endif
      end
    end
  end

  initial begin
    forever begin
      @(negedge ck);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_ready(input string what);
    int n = 0;
    @(posedge ck);
    while (!in_ready && n < 400) begin
      @(posedge ck);
      n++;
    end
    if (!in_ready) check(what, 0, 1);
  endtask

  task automatic send(input logic [W-1:0] w, input bit timed);
    exp_t e;
    int   cnt;
    @(negedge ck);
    #1;
    in_valid = 1'b1;
    in_data  = w;
    wait_ready("accept_timeout");
    @(negedge ck);
    model_word(w, e);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    if (timed) begin
      cnt = 1;
      @(posedge ck);
      check("busy_in_shift", int'(busy), 1);
      check("in_ready_in_shift", int'(in_ready), 0);
      while (!out_valid && cnt < 100) begin
        @(negedge ck);
        cnt++;
        @(posedge ck);
      end
      check("latency_edges", cnt, W + 2);
    end
  endtask

  task automatic do_reset();
    @(negedge ck);
    #1;
    rs       = 1'b0;
    in_valid = 1'b0;
    clr      = 1'b0;
    sb.delete();
    model_reset();
    @(posedge ck);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_hit1", int'(out_hit1), 0);
    check("rst_hit2", int'(out_hit2), 0);
`ifdef SEQ_SCAN_TOTALS_EN
    check("rst_total1", int'(total1), 0);
    check("rst_total2", int'(total2), 0);
`endif
    @(negedge ck);
    #1;
    rs = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    do_reset();

    // Straddling words and the basic patterns
    send(8'hA0, 1'b1);
    send(8'h55, 1'b0);
    send(8'hFF, 1'b0);
    do_reset();
    send(8'h02, 1'b0);
    send(8'h80, 1'b0);

    // Back-pressure in REPORT
    wait_ready("idle_timeout");
    @(negedge ck);
    #1;
    out_ready = 1'b0;
    send(8'h5A, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge ck);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge ck);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_hit1", int'(out_hit1), sb[0].h1);
      check("stall_hit2", int'(out_hit2), sb[0].h2);
    end
    @(negedge ck);
    #1;
    out_ready = 1'b1;
    wait_ready("release_timeout");
    check("release_busy", int'(busy), 0);

    // Reset in the middle of a scan discards the word
    send(8'h55, 1'b0);
    repeat (3) @(negedge ck);
    @(posedge ck);
    check("midscan_busy", int'(busy), 1);
    do_reset();
    send(8'hA0, 1'b0);

    // Totals saturation, then clr beating a simultaneous in_valid
    send(8'h55, 1'b0);
    send(8'h55, 1'b0);
    send(8'h55, 1'b0);
    wait_ready("preclr_timeout");
    @(negedge ck);
    #1;
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge ck);
    check("clr_in_ready", int'(in_ready), 0);
    @(negedge ck);
    model_reset();
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    @(posedge ck);
    check("clr_not_accepted", int'(busy), 0);
    check("clr_no_result", int'(out_valid), 0);
`ifdef SEQ_SCAN_TOTALS_EN
    check("clr_total1", int'(total1), 0);
    check("clr_total2", int'(total2), 0);
`endif
    send(8'h40, 1'b0);

    // Randomized traffic with random back-pressure and idle gaps
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge ck);
      send(W'($urandom), 1'b0);
    end
    @(negedge ck);
    rnd_rdy = 1'b0;
    #1;
    out_ready = 1'b1;

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge ck);
      n++;
    end
    @(posedge ck);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
